// File: rtl/reg_pipe_ce.sv
// reg_pipe_ce: WIDTH-bit, DEPTH-stage data pipeline that advances only when
// all NUM_CE clock enables are high. Each stage carries a valid tag. The
// pipeline supports a synchronous flush and keeps a registered count of how
// many stages currently hold a valid word.
//
// Optional feature macro: REG_PIPE_STALL_CNT_EN
//   When defined, the block adds a 16-bit saturating counter, o_stall_cnt.
//   It counts the edges where a valid input word was offered but could not
//   be taken because the pipe was stalled.
module reg_pipe_ce #(
    parameter int WIDTH        = 18,
    parameter int DEPTH        = 2,
    parameter int NUM_CE       = 2,
    parameter int ZERO_INVALID = 0
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NUM_CE-1:0]          i_clk_en,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_in,
    input  logic                       i_in_valid,
    output logic [WIDTH-1:0]           o_out,
    output logic                       o_out_valid,
    output logic [$clog2(DEPTH+1)-1:0] o_occupancy,
    output logic                       o_advance
`ifdef REG_PIPE_STALL_CNT_EN
    ,
    output logic [15:0]                o_stall_cnt
`endif
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [OCC_W-1:0] r_occupancy;
    logic             r_advance;

    logic             w_adv;
    logic [WIDTH-1:0] w_inData;
    logic [OCC_W:0]   w_occNext;

    // The pipe moves only when every enable is high. The input data is
    // zeroed for invalid words when that option is selected. The occupancy
    // arithmetic carries one extra bit so the add and subtract cannot wrap
    // before the result is truncated.
    always_comb begin
        w_adv     = &i_clk_en;
        w_inData  = i_in;
        if ((ZERO_INVALID != 0) && !i_in_valid) begin
            w_inData = '0;
        end
        w_occNext = {1'b0, r_occupancy}
                  + (OCC_W+1)'(i_in_valid)
                  - (OCC_W+1)'(r_valid[DEPTH-1]);
    end

    // Stage data, valid tags and occupancy update together. Flush takes
    // priority over advance, and a stall holds everything.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
            r_valid     <= '0;
            r_occupancy <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
            r_valid     <= '0;
            r_occupancy <= '0;
        end else if (w_adv) begin
            r_stage[0] <= w_inData;
            r_valid[0] <= i_in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
                r_valid[i] <= r_valid[i-1];
            end
            r_occupancy <= w_occNext[OCC_W-1:0];
        end
    end

    // Diagnostic copy of the combined enable. Flush does not affect it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_advance <= 1'b0;
        end else begin
            r_advance <= w_adv;
        end
    end

    assign o_out       = r_stage[DEPTH-1];
    assign o_out_valid = r_valid[DEPTH-1];
    assign o_occupancy = r_occupancy;
    assign o_advance   = r_advance;

`ifdef REG_PIPE_STALL_CNT_EN
    logic [15:0] r_stallCnt;

    // Count the edges where a valid word was offered but the pipe was
    // stalled. The counter saturates at all-ones, and flush clears it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stallCnt <= '0;
        end else if (i_flush) begin
            r_stallCnt <= '0;
        end else if (i_in_valid && !w_adv && (r_stallCnt != 16'hFFFF)) begin
            r_stallCnt <= r_stallCnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stallCnt;
`else
    // The stall counter is not built in this configuration.
`endif

endmodule
